// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug-dump blocks: FSM encoding, frame
// geometry and the register-index wrap helper.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PC,
    ST_REG,
    ST_CSUM
  } dump_state_e;

  localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
  localparam int unsigned PC_BYTES     = 4;
  localparam int unsigned REG_BYTES    = 128;
  localparam int unsigned FRAME_BYTES  = 1 + PC_BYTES + REG_BYTES + 1;

  // Next register-file load index, wrapping to 0 after the last dumped register.
  function automatic logic [4:0] next_reg_idx(input logic [4:0] idx,
                                              input int unsigned num_regs);
    return ((32'(idx) + 32'd1) >= num_regs) ? 5'd0 : idx + 5'd1;
  endfunction

endpackage

// File: rtl/reg_dump_streamer.sv
// Serialises PC plus the general register file into a checksummed byte frame
// over a valid/ready byte interface.
module reg_dump_streamer
  import mips_dbg_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE = HDR_BYTE_DEF,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc_in,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  dump_state_e state, state_nxt;

  logic [31:0] shift_q;
  logic [1:0]  bcnt_q;
  logic [4:0]  raddr_q;
  logic        last_q;
  logic [7:0]  csum_q;
  logic        done_q;
  logic        fire;
  logic        accept;

  assign fire     = tx_valid && tx_ready;
  // A start coinciding with the done pulse must not open a new frame.
  assign accept   = (state == ST_IDLE) && start && !done_q;
  assign rf_raddr = raddr_q;
  assign done     = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) state_nxt = ST_PC;
      end
      ST_PC: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = shift_q[31:24];
        if (tx_ready && bcnt_q == 2'd3) state_nxt = ST_REG;
      end
      ST_REG: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = shift_q[31:24];
        if (tx_ready && bcnt_q == 2'd3 && last_q) state_nxt = ST_CSUM;
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // last_q marks that the word now in the shifter is the final register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bcnt_q  <= '0;
      raddr_q <= '0;
      last_q  <= 1'b0;
      csum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        shift_q <= pc_in;
        bcnt_q  <= '0;
        raddr_q <= '0;
        last_q  <= 1'b0;
        csum_q  <= '0;
      end else if (fire) begin
        if (state == ST_PC || state == ST_REG) begin
          csum_q <= csum_q ^ shift_q[31:24];
          bcnt_q <= bcnt_q + 2'd1;
          if (bcnt_q != 2'd3) begin
            shift_q <= {shift_q[23:0], 8'h00};
          end else if (!(state == ST_REG && last_q)) begin
            shift_q <= rf_rdata;
            raddr_q <= next_reg_idx(raddr_q, NUM_REGS);
            last_q  <= (32'(raddr_q) + 32'd1) >= NUM_REGS;
          end
        end else if (state == ST_CSUM) begin
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule
